ddr3_init_sequencer: RTL

- Parametrised successor to the fixed-sequence DDR3 initialization FSM.
- Drives the JEDEC power-up sequence toward the PHY: RESET# hold, CKE wait, tXPR, a configurable number and order of MRS writes, then ZQCL.
- Uses a valid/ready command handshake with the PHY and supports re-initialization after done.
- Sits between the command scheduler and phy_layer, which owns the DRAM pins.

---
 rtl/ddr3_init_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: RESET# hold, CKE wait, tXPR, a parametrised list of
// MRS writes and a final ZQCL, issued to the PHY over a valid/ready handshake.
module ddr3_init_sequencer #(
   parameter int                    T_RESET_CYC  = 200,
   parameter int                    T_CKE_CYC    = 500,
   parameter int                    T_XPR_CYC    = 28,
   parameter int                    T_MRD_CYC    = 4,
   parameter int                    T_MOD_CYC    = 12,
   parameter int                    T_ZQINIT_CYC = 512,
   parameter int                    NUM_MR       = 4,
   parameter logic [3*NUM_MR-1:0]   MR_ORDER     = {3'd0, 3'd1, 3'd3, 3'd2},
   parameter logic [16*NUM_MR-1:0]  MR_VALUE     = '0,
   parameter int                    CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_reinit,
   input  logic        i_cmd_ready,
   output logic        o_cmd_valid,
   output logic [3:0]  o_cmd,
   output logic [2:0]  o_ba,
   output logic [15:0] o_addr,
   output logic        o_dram_reset_n,
   output logic        o_cke,
   output logic [2:0]  o_mr_idx,
   output logic        o_busy,
   output logic        o_init_done
);

   typedef enum logic [3:0] {
      IDLE,
      RST_HOLD,
      CKE_WAIT,
      XPR_WAIT,
      MRS_ISSUE,
      MRS_WAIT,
      ZQ_ISSUE,
      ZQ_WAIT,
      DONE
   } state_t;

   localparam logic [3:0]       CMD_NOP  = 4'd0;
   localparam logic [3:0]       CMD_MRS  = 4'd1;
   localparam logic [3:0]       CMD_ZQCL = 4'd2;
   localparam logic [15:0]      ZQ_ADDR  = 16'h0400;
   localparam logic [2:0]       LAST_MR  = 3'(NUM_MR - 1);

   // Timers count down from N-1 so that a timed state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_CYC - 1);
   localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR_CYC - 1);
   localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT_CYC - 1);

   state_t            state_reg;
   logic [CNT_W-1:0]  timer_reg;
   logic              dram_reset_n_reg;
   logic              cke_reg;
   logic              cmd_valid_reg;
   logic [3:0]        cmd_reg;
   logic [2:0]        ba_reg;
   logic [15:0]       addr_reg;
   logic [2:0]        mr_idx_reg;
   logic              busy_reg;
   logic              init_done_reg;

   // Unpack the MR tables into 8-entry lookups so a 3-bit index always fits.
   logic [2:0]        mr_ba  [8];
   logic [15:0]       mr_val [8];
   logic [2:0]        mr_idx_next;
   logic              timer_zero;

   for (genvar gi = 0; gi < 8; gi++) begin : g_mr
      if (gi < NUM_MR) begin : g_used
         assign mr_ba[gi]  = MR_ORDER[3*gi +: 3];
         assign mr_val[gi] = MR_VALUE[16*gi +: 16];
      end else begin : g_unused
         assign mr_ba[gi]  = '0;
         assign mr_val[gi] = '0;
      end
   end

   assign mr_idx_next = mr_idx_reg + 3'd1;
   assign timer_zero  = (timer_reg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         timer_reg        <= '0;
         dram_reset_n_reg <= 1'b0;
         cke_reg          <= 1'b0;
         cmd_valid_reg    <= 1'b0;
         cmd_reg          <= CMD_NOP;
         ba_reg           <= '0;
         addr_reg         <= '0;
         mr_idx_reg       <= '0;
         busy_reg         <= 1'b0;
         init_done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_start) begin
                  state_reg <= RST_HOLD;
                  busy_reg  <= 1'b1;
                  timer_reg <= LD_RESET;
               end
            end

            RST_HOLD: begin
               if (timer_zero) begin
                  state_reg        <= CKE_WAIT;
                  dram_reset_n_reg <= 1'b1;
                  timer_reg        <= LD_CKE;
               end else begin
                  timer_reg <= timer_reg - CNT_W'(1);
               end
            end

            CKE_WAIT: begin
               if (timer_zero) begin
                  state_reg <= XPR_WAIT;
                  cke_reg   <= 1'b1;
                  timer_reg <= LD_XPR;
               end else begin
                  timer_reg <= timer_reg - CNT_W'(1);
               end
            end

            XPR_WAIT: begin
               if (timer_zero) begin
                  state_reg     <= MRS_ISSUE;
                  cmd_valid_reg <= 1'b1;
                  cmd_reg       <= CMD_MRS;
                  ba_reg        <= mr_ba[mr_idx_reg];
                  addr_reg      <= mr_val[mr_idx_reg];
               end else begin
                  timer_reg <= timer_reg - CNT_W'(1);
               end
            end

            MRS_ISSUE: begin
               // Wait timer starts only once the PHY has taken the command.
               if (i_cmd_ready) begin
                  state_reg     <= MRS_WAIT;
                  cmd_valid_reg <= 1'b0;
                  cmd_reg       <= CMD_NOP;
                  timer_reg     <= (mr_idx_reg == LAST_MR) ? LD_MOD : LD_MRD;
               end
            end

            MRS_WAIT: begin
               if (timer_zero) begin
                  cmd_valid_reg <= 1'b1;
                  if (mr_idx_reg == LAST_MR) begin
                     state_reg <= ZQ_ISSUE;
                     cmd_reg   <= CMD_ZQCL;
                     ba_reg    <= '0;
                     addr_reg  <= ZQ_ADDR;
                  end else begin
                     state_reg  <= MRS_ISSUE;
                     cmd_reg    <= CMD_MRS;
                     mr_idx_reg <= mr_idx_next;
                     ba_reg     <= mr_ba[mr_idx_next];
                     addr_reg   <= mr_val[mr_idx_next];
                  end
               end else begin
                  timer_reg <= timer_reg - CNT_W'(1);
               end
            end

            ZQ_ISSUE: begin
               if (i_cmd_ready) begin
                  state_reg     <= ZQ_WAIT;
                  cmd_valid_reg <= 1'b0;
                  cmd_reg       <= CMD_NOP;
                  timer_reg     <= LD_ZQ;
               end
            end

            ZQ_WAIT: begin
               if (timer_zero) begin
                  state_reg     <= DONE;
                  init_done_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end else begin
                  timer_reg <= timer_reg - CNT_W'(1);
               end
            end

            DONE: begin
               // Re-initialisation drops the DRAM back into reset exactly as power-up.
               if (i_reinit) begin
                  state_reg        <= RST_HOLD;
                  init_done_reg    <= 1'b0;
                  busy_reg         <= 1'b1;
                  cke_reg          <= 1'b0;
                  dram_reset_n_reg <= 1'b0;
                  mr_idx_reg       <= '0;
                  ba_reg           <= '0;
                  addr_reg         <= '0;
                  timer_reg        <= LD_RESET;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign o_cmd_valid    = cmd_valid_reg;
   assign o_cmd          = cmd_reg;
   assign o_ba           = ba_reg;
   assign o_addr         = addr_reg;
   assign o_dram_reset_n = dram_reset_n_reg;
   assign o_cke          = cke_reg;
   assign o_mr_idx       = mr_idx_reg;
   assign o_busy         = busy_reg;
   assign o_init_done    = init_done_reg;

endmodule
